// File: rtl/smg_encode_module.sv
// smg_encode_module: 20-bit binary to 6-digit BCD (double dabble) with a scanned active-low segment driver.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above the units/decimal-point digit.
module smg_encode_module #(
    parameter int DP_POS = 6
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [19:0] Number,
    input  logic        Load,
    input  logic [5:0]  Scan_Sig,
    output logic [7:0]  SMG_Data,
    output logic        Busy,
    output logic        Done,
    output logic        Ovf
);
    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
    state_t state, state_nx;
    logic [19:0] bin;
    logic [23:0] bcd, bcd_adj, disp;
    logic [4:0]  cnt;
    logic [5:0]  lz;
    logic [2:0]  idx;
    logic        valid;
    logic [3:0]  digit;
    logic [7:0]  seg_nx;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h40;
            4'd1: seg7 = 7'h79;
            4'd2: seg7 = 7'h24;
            4'd3: seg7 = 7'h30;
            4'd4: seg7 = 7'h19;
            4'd5: seg7 = 7'h12;
            4'd6: seg7 = 7'h02;
            4'd7: seg7 = 7'h78;
            4'd8: seg7 = 7'h00;
            4'd9: seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign Busy = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = Load ? CONV : IDLE;
            CONV:    state_nx = cnt == 5'd19 ? COMMIT : CONV;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 6; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_above;
    // A digit is blank only if it and everything to its left are zero.
    always_comb begin
        lz = '0;
        zero_above = 1'b1;
        for (int i = 5; i > 0; i--) begin
            zero_above = zero_above && disp[4*i +: 4] == 4'd0;
            lz[i] = zero_above && (DP_POS > 5 || i > DP_POS);
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        valid = 1'b0;
        idx = 3'd0;
        for (int i = 0; i < 6; i++)
            if (Scan_Sig == ~(6'b1 << i)) begin
                valid = 1'b1;
                idx = 3'(i);
            end
        digit = 4'(disp >> {idx, 2'b00});
        seg_nx = (!valid || lz[idx]) ? 8'hFF : {int'(idx) != DP_POS, seg7(digit)};
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            bin <= '0;
            bcd <= '0;
            disp <= '0;
            cnt <= '0;
            Ovf <= 1'b0;
            Done <= 1'b0;
            SMG_Data <= 8'hFF;
        end else begin
            state <= state_nx;
            Done <= state == COMMIT;
            SMG_Data <= seg_nx;
            if (state == IDLE && Load) begin
                bin <= Number > 20'd999999 ? 20'd999999 : Number;
                bcd <= '0;
                cnt <= '0;
                Ovf <= Number > 20'd999999;
            end
            if (state == CONV) begin
                {bcd, bin} <= {bcd_adj[22:0], bin, 1'b0};
                cnt <= cnt + 5'd1;
            end
            if (state == COMMIT)
                disp <= bcd;
        end
    end
endmodule
